// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester channel of the dmem arbiter.
// Ports (signals): req, address, write_enable, write_mode, write_data, read_mode
// (requester -> arbiter); gnt, rvalid, read_data (arbiter -> requester).
// Modport master is the requester side; modport slave is the arbiter side.
interface dmem_arbiter_if;
    logic        req;
    logic [31:0] address;
    logic        write_enable;
    logic [2:0]  write_mode;
    logic [31:0] write_data;
    logic [2:0]  read_mode;
    logic        gnt;
    logic        rvalid;
    logic [31:0] read_data;
    modport master (output req, address, write_enable, write_mode, write_data, read_mode,
                    input gnt, rvalid, read_data);
    modport slave (input req, address, write_enable, write_mode, write_data, read_mode,
                   output gnt, rvalid, read_data);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the memory data port between master 0 (LSU) and master 1 (debug/DMA).
// Ports: clk, reset (async, active-high); m0/m1 requester channels (dmem_arbiter_if.slave);
// dmem_enable/address/write_enable/write_mode/write_data/read_enable/read_mode to memory;
// dmem_wait and dmem_read_data from memory.
// Option: define DMEM_ARB_STARVE_GUARD_EN to let master 1 win after MAX_STREAK
// consecutive contended master-0 grants; otherwise master 0 has strict priority.
module dmem_arbiter #(
    parameter int unsigned MAX_STREAK = 8
) (
    input  logic         clk,
    input  logic         reset,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic         dmem_enable,
    output logic [31:0]  dmem_address,
    output logic         dmem_write_enable,
    output logic [2:0]   dmem_write_mode,
    output logic [31:0]  dmem_write_data,
    output logic         dmem_read_enable,
    output logic [2:0]   dmem_read_mode,
    input  logic         dmem_wait,
    input  logic [31:0]  dmem_read_data
);
    logic accept, pick1, gnt0, gnt1, starved, resp;
    logic pend_valid, pend_owner, pend_read;

    if (MAX_STREAK < 1 || MAX_STREAK > 255) begin : g_bad_streak
        $error("MAX_STREAK must be in 1..255");
    end

    // Gating with reset keeps every grant and memory enable low while reset is held.
    assign accept = !dmem_wait && !reset;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [7:0] streak;
    assign starved = streak == 8'(MAX_STREAK);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            streak <= '0;
        else if (!dmem_wait)
            streak <= (gnt1 || !m1.req) ? '0 : (gnt0 && !starved) ? streak + 8'd1 : streak;
`else
    assign starved = 1'b0;
`endif

    assign pick1 = m1.req && (!m0.req || starved);
    assign gnt1  = accept && pick1;
    assign gnt0  = accept && m0.req && !pick1;
    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    assign dmem_enable       = gnt0 || gnt1;
    assign dmem_address      = gnt1 ? m1.address    : gnt0 ? m0.address    : '0;
    assign dmem_write_mode   = gnt1 ? m1.write_mode : gnt0 ? m0.write_mode : '0;
    assign dmem_write_data   = gnt1 ? m1.write_data : gnt0 ? m0.write_data : '0;
    assign dmem_read_mode    = gnt1 ? m1.read_mode  : gnt0 ? m0.read_mode  : '0;
    assign dmem_write_enable = gnt1 ? m1.write_enable  : gnt0 && m0.write_enable;
    assign dmem_read_enable  = gnt1 ? !m1.write_enable : gnt0 && !m0.write_enable;

    // The pending slot describes the access issued in the last accept cycle; its
    // response is delivered in the next accept cycle, so a stall simply freezes it.
    assign resp = accept && pend_valid && pend_read;
    assign m0.rvalid = resp && !pend_owner;
    assign m1.rvalid = resp && pend_owner;
    assign m0.read_data = dmem_read_data;
    assign m1.read_data = dmem_read_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pend_valid <= 1'b0;
            pend_owner <= 1'b0;
            pend_read  <= 1'b0;
        end else if (!dmem_wait) begin
            pend_valid <= dmem_enable;
            pend_owner <= gnt1;
            pend_read  <= dmem_read_enable;
        end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small memory model.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dmem_enable, dmem_write_enable, dmem_read_enable;
    logic [31:0] dmem_address, dmem_write_data;
    logic [2:0]  dmem_write_mode, dmem_read_mode;
    logic        dmem_wait;
    logic [31:0] dmem_read_data, hold;
    int vectors = 0;
    int errors = 0;

    dmem_arbiter_if m0_if();
    dmem_arbiter_if m1_if();

    dmem_arbiter #(.MAX_STREAK(8)) dut (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
        .dmem_enable(dmem_enable), .dmem_address(dmem_address),
        .dmem_write_enable(dmem_write_enable), .dmem_write_mode(dmem_write_mode),
        .dmem_write_data(dmem_write_data), .dmem_read_enable(dmem_read_enable),
        .dmem_read_mode(dmem_read_mode), .dmem_wait(dmem_wait),
        .dmem_read_data(dmem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model: data = address ^ 0xA5A50000; unaligned accesses stall one cycle.
    logic [1:0] mode;
    logic       unaligned;
    assign mode = dmem_write_enable ? dmem_write_mode[1:0] : dmem_read_mode[1:0];
    assign unaligned = (mode == 2'd2 && dmem_address[1:0] != 2'd0) || (mode == 2'd1 && dmem_address[1:0] == 2'd3);
    always @(posedge clk or posedge reset)
        if (reset) begin
            dmem_wait <= 1'b0;
            dmem_read_data <= '0;
            hold <= '0;
        end else if (dmem_wait) begin
            dmem_wait <= 1'b0;
            dmem_read_data <= hold;
        end else if (dmem_enable && unaligned) begin
            dmem_wait <= 1'b1;
            hold <= dmem_address ^ 32'hA5A5_0000;
        end else if (dmem_enable)
            dmem_read_data <= dmem_address ^ 32'hA5A5_0000;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
        m0_if.req = r; m0_if.address = a; m0_if.write_enable = w; m0_if.write_data = d;
        m0_if.write_mode = 3'd2; m0_if.read_mode = 3'd2;
    endtask

    task automatic drv1(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
        m1_if.req = r; m1_if.address = a; m1_if.write_enable = w; m1_if.write_data = d;
        m1_if.write_mode = 3'd2; m1_if.read_mode = 3'd2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drv0(1'b1, 32'h8000_0000, 1'b0, '0);
        drv1(1'b1, 32'h8000_0004, 1'b0, '0);
        cyc(); cyc();
        vectors++;
        if ({m0_if.gnt, m1_if.gnt, dmem_enable, m0_if.rvalid, m1_if.rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold: gnt0/gnt1/en/rv0/rv1 got %b expected 00000",
                     {m0_if.gnt, m1_if.gnt, dmem_enable, m0_if.rvalid, m1_if.rvalid});
        end
        reset = 1'b0;
        drv1(1'b0, '0, 1'b0, '0);
        #1;
        vectors++;
        if ({m0_if.gnt, dmem_enable, dmem_read_enable, dmem_address} !== {3'b111, 32'h8000_0000}) begin
            errors++;
            $display("FAIL reset_first_gnt: gnt/en/ren/addr got %b %b %b %h expected 1 1 1 80000000",
                     m0_if.gnt, dmem_enable, dmem_read_enable, dmem_address);
        end
        cyc();
        reset = 1'b1;
        drv0(1'b0, '0, 1'b0, '0);
        #1;
        vectors++;
        if ({m0_if.rvalid, m1_if.rvalid, dmem_enable} !== 3'b0) begin
            errors++;
            $display("FAIL reset_midload: rv0/rv1/en got %b expected 000", {m0_if.rvalid, m1_if.rvalid, dmem_enable});
        end
        cyc();
        reset = 1'b0;
        #1;
        vectors++;
        if ({m0_if.rvalid, m1_if.rvalid} !== 2'b0) begin
            errors++;
            $display("FAIL reset_dropped: rv0/rv1 got %b expected 00", {m0_if.rvalid, m1_if.rvalid});
        end
        cyc();
    endtask

    task automatic test_aligned();
        for (int i = 0; i < 5; i++) begin
            drv0(i < 3, 32'h8000_0000 + 32'(4 * i), 1'b0, '0);
            #1;
            vectors++;
            if (m0_if.gnt !== (i < 3)) begin
                errors++;
                $display("FAIL aligned_gnt[%0d]: got %b expected %b", i, m0_if.gnt, i < 3);
            end
            vectors++;
            if ({m0_if.rvalid, m1_if.rvalid} !== {i >= 1 && i <= 3, 1'b0}) begin
                errors++;
                $display("FAIL aligned_rvalid[%0d]: rv0/rv1 got %b%b expected %b0", i, m0_if.rvalid, m1_if.rvalid, i >= 1 && i <= 3);
            end
            if (i >= 1 && i <= 3) begin
                vectors++;
                if (m0_if.read_data !== 32'h25A5_0000 + 32'(4 * (i - 1))) begin
                    errors++;
                    $display("FAIL aligned_data[%0d]: got %h expected %h", i, m0_if.read_data, 32'h25A5_0000 + 32'(4 * (i - 1)));
                end
            end
            cyc();
        end
    endtask

    task automatic test_unaligned();
        drv1(1'b1, 32'h8000_0002, 1'b0, '0);
        #1;
        vectors++;
        if ({m1_if.gnt, m0_if.gnt, dmem_address} !== {2'b10, 32'h8000_0002}) begin
            errors++;
            $display("FAIL unal_gnt: gnt1/gnt0/addr got %b %b %h expected 1 0 80000002", m1_if.gnt, m0_if.gnt, dmem_address);
        end
        cyc();
        drv1(1'b0, '0, 1'b0, '0);
        drv0(1'b1, 32'h8000_0010, 1'b0, '0);
        #1;
        vectors++;
        if ({dmem_wait, m0_if.gnt, m1_if.gnt, dmem_enable, m0_if.rvalid, m1_if.rvalid} !== 6'b100000) begin
            errors++;
            $display("FAIL unal_stall: wait/gnt0/gnt1/en/rv0/rv1 got %b expected 100000",
                     {dmem_wait, m0_if.gnt, m1_if.gnt, dmem_enable, m0_if.rvalid, m1_if.rvalid});
        end
        cyc();
        vectors++;
        if ({m1_if.rvalid, m0_if.rvalid, m0_if.gnt, m1_if.read_data} !== {3'b101, 32'h25A5_0002}) begin
            errors++;
            $display("FAIL unal_resp: rv1/rv0/gnt0/data got %b %b %b %h expected 1 0 1 25a50002",
                     m1_if.rvalid, m0_if.rvalid, m0_if.gnt, m1_if.read_data);
        end
        cyc();
        drv0(1'b0, '0, 1'b0, '0);
        #1;
        vectors++;
        if ({m0_if.rvalid, m1_if.rvalid, m0_if.read_data} !== {2'b10, 32'h25A5_0010}) begin
            errors++;
            $display("FAIL unal_next: rv0/rv1/data got %b %b %h expected 1 0 25a50010", m0_if.rvalid, m1_if.rvalid, m0_if.read_data);
        end
        cyc();
    endtask

    task automatic test_mixed();
        drv0(1'b1, 32'h8000_0020, 1'b1, 32'hDEAD_BEEF);
        #1;
        vectors++;
        if ({m0_if.gnt, dmem_write_enable, dmem_read_enable, dmem_write_mode, dmem_write_data} !== {3'b110, 3'd2, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL mixed_store: gnt0/we/re/wmode/wdata got %b %b %b %0d %h expected 1 1 0 2 deadbeef",
                     m0_if.gnt, dmem_write_enable, dmem_read_enable, dmem_write_mode, dmem_write_data);
        end
        cyc();
        drv0(1'b0, '0, 1'b0, '0);
        drv1(1'b1, 32'h8000_0024, 1'b0, '0);
        #1;
        vectors++;
        if ({m1_if.gnt, m0_if.rvalid, m1_if.rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL mixed_t1: gnt1/rv0/rv1 got %b expected 100", {m1_if.gnt, m0_if.rvalid, m1_if.rvalid});
        end
        cyc();
        drv1(1'b0, '0, 1'b0, '0);
        #1;
        vectors++;
        if ({m1_if.rvalid, m0_if.rvalid, m1_if.read_data} !== {2'b10, 32'h25A5_0024}) begin
            errors++;
            $display("FAIL mixed_t2: rv1/rv0/data got %b %b %h expected 1 0 25a50024", m1_if.rvalid, m0_if.rvalid, m1_if.read_data);
        end
        cyc();
        vectors++;
        if ({m0_if.rvalid, m1_if.rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL mixed_t3: rv0/rv1 got %b expected 00", {m0_if.rvalid, m1_if.rvalid});
        end
        cyc();
    endtask

    task automatic test_starvation();
        logic exp, prev;
        prev = 1'b0;
        drv0(1'b1, 32'h8000_0040, 1'b0, '0);
        drv1(1'b1, 32'h8000_0080, 1'b0, '0);
        for (int i = 0; i < 27; i++) begin
`ifdef DMEM_ARB_STARVE_GUARD_EN
            exp = (i % 9) == 8;
`else
            exp = 1'b0;
`endif
            #1;
            vectors++;
            if ({m0_if.gnt, m1_if.gnt} !== {!exp, exp}) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: gnt0/gnt1 got %b%b expected %b%b", i, m0_if.gnt, m1_if.gnt, !exp, exp);
            end
            if (i > 0) begin
                vectors++;
                if ({m0_if.rvalid, m1_if.rvalid} !== {!prev, prev}) begin
                    errors++;
                    $display("FAIL starve_rvalid[%0d]: rv0/rv1 got %b%b expected %b%b", i, m0_if.rvalid, m1_if.rvalid, !prev, prev);
                end
            end
            prev = exp;
            cyc();
        end
        drv0(1'b0, '0, 1'b0, '0);
        drv1(1'b0, '0, 1'b0, '0);
        cyc();
    endtask

    initial begin
        drv0(1'b0, '0, 1'b0, '0);
        drv1(1'b0, '0, 1'b0, '0);
        test_reset();
        test_aligned();
        test_unaligned();
        test_mixed();
        test_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
